// File: rtl/l1_cache_pkg.sv
// Geometry constants, FSM state codes and line/word helpers for the L1 controller.
// Latency: none (package only).
// Backpressure: none (package only).
package l1_cache_pkg;

    localparam int ADDR_BITS      = 32;
    localparam int WORD_BITS      = 32;
    localparam int LINE_BITS      = 512;
    localparam int NUM_SETS       = 64;
    localparam int NUM_WAYS       = 2;
    localparam int SET_BITS       = 6;
    localparam int TAG_BITS       = 20;
    localparam int WORD_SEL_BITS  = 4;
    localparam int WORDS_PER_LINE = 16;

    // Controller state encoding
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_FILL_REQ  = 3'd1;
    localparam logic [2:0] ST_FILL_WAIT = 3'd2;
    localparam logic [2:0] ST_FILL_WR   = 3'd3;
    localparam logic [2:0] ST_WHIT_WR   = 3'd4;
    localparam logic [2:0] ST_MWR_REQ   = 3'd5;
    localparam logic [2:0] ST_MWR_WAIT  = 3'd6;

    // Word sel of a line; word 0 sits in the least significant bits.
    function automatic logic [WORD_BITS-1:0] line_word(input logic [LINE_BITS-1:0] line,
                                                       input logic [WORD_SEL_BITS-1:0] sel);
        return line[{sel, 5'b00000} +: WORD_BITS];
    endfunction

    // Line with word sel replaced by a new value.
    function automatic logic [LINE_BITS-1:0] line_merge(input logic [LINE_BITS-1:0] line,
                                                        input logic [WORD_SEL_BITS-1:0] sel,
                                                        input logic [WORD_BITS-1:0] word);
        logic [LINE_BITS-1:0] res;
        res = line;
        res[{sel, 5'b00000} +: WORD_BITS] = word;
        return res;
    endfunction

endpackage

// File: rtl/cache_data_array.sv
// Two-way line storage: 2 ways x 64 sets x 512 bits, steered by the controller's hit/LRU lines.
// Latency: combinational read, write on the rising edge when write_en is high.
// Backpressure: none; every write strobe is taken on the edge it is presented.
module cache_data_array
    import l1_cache_pkg::*;
(
    input  logic                 clk,
    input  logic [SET_BITS-1:0]  index,
    input  logic [LINE_BITS-1:0] data_in,
    input  logic                 write_en,
    input  logic                 way0_hit,
    input  logic                 way1_hit,
    input  logic                 lru_bit,
    output logic [LINE_BITS-1:0] data_out
);

    logic [LINE_BITS-1:0] way0_mem [NUM_SETS];
    logic [LINE_BITS-1:0] way1_mem [NUM_SETS];
    logic                 wr_way;

    // Read the hit way; with no hit way0 is presented and simply ignored by the controller.
    always_comb begin
        data_out = way1_hit ? way1_mem[index] : way0_mem[index];
        wr_way   = way0_hit ? 1'b0 : (way1_hit ? 1'b1 : lru_bit);
    end

    // Line write into the hit way, or the LRU victim on a fill.
    always_ff @(posedge clk) begin
        if (write_en) begin
            if (wr_way) begin
                way1_mem[index] <= data_in;
            end else begin
                way0_mem[index] <= data_in;
            end
        end
    end

endmodule

// File: rtl/l1_cache_controller.sv
// 2-way write-through, no-write-allocate L1 controller owning tag/valid/LRU state.
// Latency: read hit answers on the accept edge; miss = request + memory latency + 1 fill edge.
// Backpressure: ready_stall high while busy; strobes are only sampled in IDLE.
module l1_cache_controller
    import l1_cache_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [31:0]          phy_addr,
    input  logic [31:0]          data_from_cpu,
    input  logic                 read_mem,
    input  logic                 write_mem,
    output logic [31:0]          data_to_cpu,
    output logic                 hit_miss,
    output logic                 ready_stall,
    output logic [5:0]           cache_mem_index,
    output logic [511:0]         cache_mem_data_in,
    output logic                 cache_mem_write_en,
    input  logic [511:0]         cache_mem_data_out,
    output logic                 way0_hit,
    output logic                 way1_hit,
    output logic                 lru_bit,
    output logic [31:0]          main_mem_addr,
    output logic [31:0]          main_mem_data_out,
    output logic                 main_mem_read_req,
    output logic                 main_mem_write_req,
    input  logic [511:0]         main_mem_data_in,
    input  logic                 main_mem_ready
);

    logic [2:0]           state;
    logic [31:2]          addr_q;
    logic [31:0]          wdata_q;
    logic [LINE_BITS-1:0] fill_q;

    logic [TAG_BITS-1:0]  tag_way0 [NUM_SETS];
    logic [TAG_BITS-1:0]  tag_way1 [NUM_SETS];
    logic [NUM_SETS-1:0]  valid_way0;
    logic [NUM_SETS-1:0]  valid_way1;
    logic [NUM_SETS-1:0]  lru_q;

    logic [SET_BITS-1:0]  cur_set;
    logic [TAG_BITS-1:0]  cur_tag;
    logic                 match0;
    logic                 match1;
    logic                 addr_lsb_unused;

    // Byte offset within a word plays no part in a word-granular cache.
    assign addr_lsb_unused = ^phy_addr[1:0];

    // Lookup address: live CPU address in IDLE, otherwise the request latched at accept.
    always_comb begin
        cur_set = (state == ST_IDLE) ? phy_addr[11:6]  : addr_q[11:6];
        cur_tag = (state == ST_IDLE) ? phy_addr[31:12] : addr_q[31:12];
        match0  = valid_way0[cur_set] && (tag_way0[cur_set] == cur_tag);
        match1  = valid_way1[cur_set] && (tag_way1[cur_set] == cur_tag);
    end

    // Data-array steering; during a fill the latched address cannot match, so both hits are 0
    // and the array falls back to the LRU way.
    always_comb begin
        way0_hit           = match0;
        way1_hit           = match1;
        lru_bit            = lru_q[cur_set];
        cache_mem_index    = cur_set;
        ready_stall        = (state != ST_IDLE);
        cache_mem_write_en = (state == ST_FILL_WR) || (state == ST_WHIT_WR);
        cache_mem_data_in  = '0;
        if (state == ST_FILL_WR) begin
            cache_mem_data_in = fill_q;
        end else if (state == ST_WHIT_WR) begin
            cache_mem_data_in = line_merge(cache_mem_data_out, addr_q[5:2], wdata_q);
        end
    end

    // Request FSM, CPU result registers and memory-side request registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= ST_IDLE;
            addr_q             <= '0;
            wdata_q            <= '0;
            fill_q             <= '0;
            hit_miss           <= 1'b0;
            data_to_cpu        <= '0;
            main_mem_addr      <= '0;
            main_mem_data_out  <= '0;
            main_mem_read_req  <= 1'b0;
            main_mem_write_req <= 1'b0;
        end else begin
            main_mem_read_req  <= 1'b0;
            main_mem_write_req <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (read_mem) begin
                        addr_q   <= phy_addr[31:2];
                        hit_miss <= match0 | match1;
                        if (match0 | match1) begin
                            data_to_cpu <= line_word(cache_mem_data_out, phy_addr[5:2]);
                        end else begin
                            state             <= ST_FILL_REQ;
                            main_mem_read_req <= 1'b1;
                            main_mem_addr     <= {phy_addr[31:6], 6'b000000};
                        end
                    end else if (write_mem) begin
                        addr_q   <= phy_addr[31:2];
                        wdata_q  <= data_from_cpu;
                        hit_miss <= match0 | match1;
                        if (match0 | match1) begin
                            state <= ST_WHIT_WR;
                        end else begin
                            state              <= ST_MWR_REQ;
                            main_mem_write_req <= 1'b1;
                            main_mem_addr      <= {phy_addr[31:2], 2'b00};
                            main_mem_data_out  <= data_from_cpu;
                        end
                    end
                end
                ST_FILL_REQ:  state <= ST_FILL_WAIT;
                ST_FILL_WAIT: begin
                    if (main_mem_ready) begin
                        fill_q <= main_mem_data_in;
                        state  <= ST_FILL_WR;
                    end
                end
                ST_FILL_WR: begin
                    data_to_cpu <= line_word(fill_q, addr_q[5:2]);
                    state       <= ST_IDLE;
                end
                ST_WHIT_WR: begin
                    state              <= ST_MWR_REQ;
                    main_mem_write_req <= 1'b1;
                    main_mem_addr      <= {addr_q, 2'b00};
                    main_mem_data_out  <= wdata_q;
                end
                ST_MWR_REQ:   state <= ST_MWR_WAIT;
                ST_MWR_WAIT: begin
                    if (main_mem_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default:      state <= ST_IDLE;
            endcase
        end
    end

    // Valid and LRU bookkeeping; lru_q[set] names the way to evict next.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_way0 <= '0;
            valid_way1 <= '0;
            lru_q      <= '0;
        end else begin
            if ((state == ST_IDLE && read_mem && (match0 | match1)) || state == ST_WHIT_WR) begin
                lru_q[cur_set] <= match0;
            end else if (state == ST_FILL_WR) begin
                if (lru_q[cur_set]) begin
                    valid_way1[cur_set] <= 1'b1;
                end else begin
                    valid_way0[cur_set] <= 1'b1;
                end
                lru_q[cur_set] <= ~lru_q[cur_set];
            end
        end
    end

    // Tag capture for the victim way on a fill; tags are qualified by valid, so no reset.
    always_ff @(posedge clk) begin
        if (state == ST_FILL_WR) begin
            if (lru_q[cur_set]) begin
                tag_way1[cur_set] <= cur_tag;
            end else begin
                tag_way0[cur_set] <= cur_tag;
            end
        end
    end

endmodule

// File: tb/tb_l1_cache_controller.sv
// Self-checking bench: directed scenarios with literal expectations plus randomized traffic
// checked against a tag/LRU-list model and a word-level memory image.
// Memory responder answers every request 4 cycles later with a one-cycle ready pulse.
module tb_l1_cache_controller;
    import l1_cache_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [31:0]  phy_addr = '0;
    logic [31:0]  data_from_cpu = '0;
    logic         read_mem = 1'b0;
    logic         write_mem = 1'b0;
    logic [31:0]  data_to_cpu;
    logic         hit_miss;
    logic         ready_stall;
    logic [5:0]   cache_mem_index;
    logic [511:0] cache_mem_data_in;
    logic         cache_mem_write_en;
    logic [511:0] cache_mem_data_out;
    logic         way0_hit;
    logic         way1_hit;
    logic         lru_bit;
    logic [31:0]  main_mem_addr;
    logic [31:0]  main_mem_data_out;
    logic         main_mem_read_req;
    logic         main_mem_write_req;
    logic [511:0] main_mem_data_in;
    logic         main_mem_ready;

    always #5 clk = ~clk;

    l1_cache_controller dut (
        .clk(clk), .rst_n(rst_n), .phy_addr(phy_addr), .data_from_cpu(data_from_cpu),
        .read_mem(read_mem), .write_mem(write_mem), .data_to_cpu(data_to_cpu),
        .hit_miss(hit_miss), .ready_stall(ready_stall), .cache_mem_index(cache_mem_index),
        .cache_mem_data_in(cache_mem_data_in), .cache_mem_write_en(cache_mem_write_en),
        .cache_mem_data_out(cache_mem_data_out), .way0_hit(way0_hit), .way1_hit(way1_hit),
        .lru_bit(lru_bit), .main_mem_addr(main_mem_addr), .main_mem_data_out(main_mem_data_out),
        .main_mem_read_req(main_mem_read_req), .main_mem_write_req(main_mem_write_req),
        .main_mem_data_in(main_mem_data_in), .main_mem_ready(main_mem_ready)
    );

    cache_data_array arr (
        .clk(clk), .index(cache_mem_index), .data_in(cache_mem_data_in),
        .write_en(cache_mem_write_en), .way0_hit(way0_hit), .way1_hit(way1_hit),
        .lru_bit(lru_bit), .data_out(cache_mem_data_out)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- memory images ----------------
    logic [31:0] phys_mem  [int];   // what the DUT wrote to memory
    logic [31:0] model_mem [int];   // what the CPU stored (reference)

    function automatic logic [31:0] phys_rd(input int k);
        if (phys_mem.exists(k)) return phys_mem[k];
        return 32'h0000_0002;
    endfunction

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        int k;
        k = int'(a[31:2]);
        if (model_mem.exists(k)) return model_mem[k];
        return 32'h0000_0002;
    endfunction

    // ---------------- cache model: per-set recency list of up to two tags ----------------
    int          m_cnt [64];
    logic [19:0] m_mru [64];
    logic [19:0] m_lru [64];

    function automatic bit m_lookup(input logic [31:0] a);
        int s;
        s = int'(a[11:6]);
        return (m_cnt[s] >= 1 && m_mru[s] == a[31:12]) || (m_cnt[s] == 2 && m_lru[s] == a[31:12]);
    endfunction

    task automatic m_touch(input logic [31:0] a);
        int s;
        s = int'(a[11:6]);
        if (m_cnt[s] == 2 && m_lru[s] == a[31:12]) begin
            m_lru[s] = m_mru[s];
            m_mru[s] = a[31:12];
        end
    endtask

    task automatic m_fill(input logic [31:0] a);
        int s;
        s = int'(a[11:6]);
        if (m_cnt[s] == 0) begin
            m_mru[s] = a[31:12];
            m_cnt[s] = 1;
        end else begin
            m_lru[s] = m_mru[s];
            m_mru[s] = a[31:12];
            m_cnt[s] = 2;
        end
    endtask

    task automatic m_clear();
        for (int s = 0; s < 64; s++) m_cnt[s] = 0;
    endtask

    // ---------------- main memory responder ----------------
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    logic [31:0] last_rd_addr = '0;
    logic [31:0] last_wr_addr = '0;
    logic [31:0] last_wr_data = '0;

    initial begin
        logic [31:0]  cap_a;
        logic [31:0]  cap_d;
        logic [511:0] line;
        bit           is_rd;
        bit           live;
        main_mem_ready   = 1'b0;
        main_mem_data_in = '0;
        forever begin
            @(negedge clk);
            if (rst_n && (main_mem_read_req || main_mem_write_req)) begin
                chk("req_exclusive", 32'(main_mem_read_req & main_mem_write_req), 32'd0);
                is_rd = main_mem_read_req;
                cap_a = main_mem_addr;
                cap_d = main_mem_data_out;
                live  = 1'b1;
                line  = '0;
                if (is_rd) begin
                    rd_cnt++;
                    last_rd_addr = cap_a;
                    for (int w = 0; w < 16; w++)
                        line[w*32 +: 32] = phys_rd(int'({cap_a[31:6], 4'(w)}));
                end else begin
                    wr_cnt++;
                    last_wr_addr = cap_a;
                    last_wr_data = cap_d;
                    phys_mem[int'(cap_a[31:2])] = cap_d;
                end
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    if (!rst_n) live = 1'b0;
                    if (live) begin
                        chk("mem_addr_hold", main_mem_addr, cap_a);
                        chk("req_no_reassert", 32'({main_mem_read_req, main_mem_write_req}), 32'd0);
                        if (!is_rd) chk("mem_wdata_hold", main_mem_data_out, cap_d);
                    end
                end
                main_mem_data_in = line;
                main_mem_ready   = 1'b1;
                @(negedge clk);
                main_mem_ready   = 1'b0;
            end
        end
    end

    // ---------------- one CPU transaction, checked against the model ----------------
    task automatic txn(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d,
                       input bit noise, input bit lit_en, input bit lit_hit,
                       input logic [31:0] lit_data);
        bit          exp_hit;
        logic [31:0] exp_data;
        int          rc0, wc0, k;
        exp_hit  = m_lookup(a);
        exp_data = model_rd(a);
        rc0 = rd_cnt;
        wc0 = wr_cnt;
        phy_addr      = a;
        data_from_cpu = d;
        read_mem      = rd;
        write_mem     = wr;
        @(negedge clk);
        read_mem  = 1'b0;
        write_mem = 1'b0;
        chk("hit_miss", 32'(hit_miss), 32'(exp_hit));
        if (lit_en) chk("hit_miss_lit", 32'(hit_miss), 32'(lit_hit));
        if (rd && exp_hit) begin
            chk("rhit_no_stall", 32'(ready_stall), 32'd0);
        end else begin
            chk("busy_after_accept", 32'(ready_stall), 32'd1);
            k = 0;
            while (ready_stall && k < 80) begin
                if (noise) begin
                    phy_addr      = $urandom;
                    data_from_cpu = $urandom;
                    read_mem      = 1'($urandom_range(0, 1));
                    write_mem     = 1'($urandom_range(0, 1));
                end
                @(negedge clk);
                k++;
            end
            read_mem  = 1'b0;
            write_mem = 1'b0;
            phy_addr  = a;
            if (k >= 80) chk("txn_timeout", 32'(ready_stall), 32'd0);
        end
        if (rd) begin
            chk("rd_data", data_to_cpu, exp_data);
            if (lit_en) chk("rd_data_lit", data_to_cpu, lit_data);
        end
        chk("hit_held", 32'(hit_miss), 32'(exp_hit));
        chk("mem_rd_count", 32'(rd_cnt), 32'(rc0 + ((rd && !exp_hit) ? 1 : 0)));
        chk("mem_wr_count", 32'(wr_cnt), 32'(wc0 + (rd ? 0 : 1)));
        if (rd && !exp_hit) chk("fill_addr", last_rd_addr, {a[31:6], 6'b000000});
        if (!rd) begin
            chk("wt_addr", last_wr_addr, {a[31:2], 2'b00});
            chk("wt_data", last_wr_data, d);
        end
        if (exp_hit) m_touch(a);
        else if (rd) m_fill(a);
        if (!rd) model_mem[int'(a[31:2])] = d;
    endtask

    // Asynchronous reset mid-cycle; all outputs must clear at once.
    task automatic do_reset(input int hold);
        phy_addr  = '0;
        read_mem  = 1'b0;
        write_mem = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_ready_stall", 32'(ready_stall), 32'd0);
        chk("rst_hit_miss", 32'(hit_miss), 32'd0);
        chk("rst_data_to_cpu", data_to_cpu, 32'd0);
        chk("rst_reqs", 32'({main_mem_read_req, main_mem_write_req}), 32'd0);
        chk("rst_mem_addr", main_mem_addr, 32'd0);
        chk("rst_mem_wdata", main_mem_data_out, 32'd0);
        chk("rst_cache_we", 32'(cache_mem_write_en), 32'd0);
        chk("rst_cache_din", 32'(|cache_mem_data_in), 32'd0);
        chk("rst_way_hits_lru", 32'({way0_hit, way1_hit, lru_bit}), 32'd0);
        chk("rst_index", 32'(cache_mem_index), 32'd0);
        repeat (hold) @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        m_clear();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [19:0] tg;
        logic [5:0]  st;
        bit          rd, wr;
        m_clear();
        @(negedge clk);
        do_reset(2);

        // Basic fill, hit, write-through hit, write miss then fill.
        txn(1, 0, 32'h0000_0000, 32'h0, 0, 1, 0, 32'h0000_0002);
        txn(1, 0, 32'h0000_0000, 32'h0, 0, 1, 1, 32'h0000_0002);
        txn(0, 1, 32'h0000_0004, 32'hDEAD_BEEF, 0, 1, 1, 32'h0);
        txn(1, 0, 32'h0000_0004, 32'h0, 0, 1, 1, 32'hDEAD_BEEF);
        txn(0, 1, 32'h0000_3000, 32'h1234_5678, 0, 1, 0, 32'h0);
        txn(1, 0, 32'h0000_3000, 32'h0, 0, 1, 0, 32'h1234_5678);

        // LRU eviction in set 0.
        do_reset(2);
        txn(1, 0, 32'h0000_0000, 32'h0, 0, 1, 0, 32'h0000_0002);
        txn(1, 0, 32'h0000_1000, 32'h0, 0, 1, 0, 32'h0000_0002);
        txn(1, 0, 32'h0000_0000, 32'h0, 0, 1, 1, 32'h0000_0002);
        txn(1, 0, 32'h0000_2000, 32'h0, 0, 1, 0, 32'h0000_0002);
        txn(1, 0, 32'h0000_1000, 32'h0, 0, 1, 0, 32'h0000_0002);
        txn(1, 0, 32'h0000_0000, 32'h0, 0, 1, 0, 32'h0000_0002);
        // Both strobes: the read wins, no memory write.
        txn(1, 1, 32'h0000_0000, 32'h0000_0099, 0, 1, 1, 32'h0000_0002);

        // Reset while waiting for a fill; the late ready must be ignored.
        phy_addr = 32'h0000_0040;
        read_mem = 1'b1;
        @(negedge clk);
        read_mem = 1'b0;
        @(negedge clk);
        @(negedge clk);
        do_reset(1);
        chk("post_rst_idle", 32'(ready_stall), 32'd0);
        chk("post_rst_no_write", 32'(cache_mem_write_en), 32'd0);
        repeat (3) @(negedge clk);
        chk("post_rst_still_idle", 32'(ready_stall), 32'd0);
        txn(1, 0, 32'h0000_0040, 32'h0, 0, 1, 0, 32'h0000_0002);

        // Randomized traffic over a small set/tag pool to force hits and evictions.
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 3))
                0: tg = 20'h00000;
                1: tg = 20'h00001;
                2: tg = 20'h00002;
                default: tg = 20'hA5A5A;
            endcase
            case ($urandom_range(0, 2))
                0: st = 6'd0;
                1: st = 6'd1;
                default: st = 6'd63;
            endcase
            a  = {tg, st, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
            rd = ($urandom_range(0, 9) < 6);
            wr = !rd || ($urandom_range(0, 9) == 0);
            txn(rd, wr, a, $urandom, 1'($urandom_range(0, 1)), 0, 0, 32'h0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (8) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
